dmem_bridge: RTL and testbench



---
 rtl/toast_dmem_pkg.sv | 33 +++
 rtl/dmem_tx_fifo.sv | 61 ++++++
 rtl/dmem_bridge.sv | 116 +++++++++++
 tb/tb_dmem_bridge.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/toast_dmem_pkg.sv
// rtl/toast_dmem_pkg.sv - shared MMIO map, STATUS layout and region type for dmem_bridge
package toast_dmem_pkg;

  localparam logic [7:0] OFS_TIMER_LO   = 8'h00;
  localparam logic [7:0] OFS_TIMER_HI   = 8'h04;
  localparam logic [7:0] OFS_TIMECMP_LO = 8'h08;
  localparam logic [7:0] OFS_TIMECMP_HI = 8'h0C;
  localparam logic [7:0] OFS_TX_DATA    = 8'h10;
  localparam logic [7:0] OFS_STATUS     = 8'h14;

  localparam int STS_FULL      = 0;
  localparam int STS_EMPTY     = 1;
  localparam int STS_COUNT_LSB = 2;
  localparam int STS_COUNT_MSB = 4;
  localparam int STS_OVF       = 5;

  typedef enum logic {
    REG_RAM  = 1'b0,
    REG_MMIO = 1'b1
  } region_e;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic [2:0] cnt, input logic ovf);
    logic [31:0] s;
    s = '0;
    s[STS_FULL]                    = full;
    s[STS_EMPTY]                   = empty;
    s[STS_COUNT_MSB:STS_COUNT_LSB] = cnt;
    s[STS_OVF]                     = ovf;
    return s;
  endfunction

endpackage

// File: rtl/dmem_tx_fifo.sv
// rtl/dmem_tx_fifo.sv - transmit byte FIFO; a push into a full FIFO is accepted only alongside a pop
module dmem_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  logic [7:0]                  push_data_i,
  output logic                        pop_valid_o,
  input  logic                        pop_ready_i,
  output logic [7:0]                  pop_data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          pop, push_ok;

  assign full_o      = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign pop_valid_o = !empty_o;
  assign pop_data_o  = mem_q[rp_q];
  assign count_o     = cnt_q;

  assign pop     = pop_valid_o && pop_ready_i;
  assign push_ok = push_i && (!full_o || pop);

  always_comb begin
    rp_d  = rp_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (pop)     rp_d = rp_q + 1'b1;
    if (push_ok) wp_d = wp_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared on reset so the head byte reads 0 out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) mem_q[wp_q] <= push_data_i;
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - DMEM decode to word RAM or MMIO (64-bit timer, TX FIFO), registered read data
module dmem_bridge
  import toast_dmem_pkg::*;
#(
  parameter int          RAM_DEPTH  = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] DMEM_addr,
  input  logic [31:0] DMEM_wr_data,
  input  logic        DMEM_wr_en,
  input  logic        DMEM_rst,
  output logic [31:0] DMEM_rd_data,
  output logic [7:0]  Tx_data,
  output logic        Tx_valid,
  input  logic        Tx_ready,
  output logic        Timer_irq
);

  localparam int RAW = $clog2(RAM_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  region_e        region;
  logic [RAW-1:0] word_idx;
  logic [7:0]     ofs;
  logic           mmio_wr, mmio_rd, tx_push, tx_pop, tx_full, tx_empty;
  logic [CW-1:0]  tx_count;
  logic           unused_addr;

  logic [31:0] ram_q [RAM_DEPTH];
  logic [31:0] rd_data_q, rd_data_d;
  logic [63:0] mtime_q, mtimecmp_q, mtimecmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic        ovf_q, ovf_d, irq_q;

  assign region   = (DMEM_addr[31] == MMIO_BASE[31]) ? REG_MMIO : REG_RAM;
  assign word_idx = DMEM_addr[RAW+1:2];
  assign ofs      = {DMEM_addr[7:2], 2'b00};
  assign mmio_wr  = (region == REG_MMIO) && DMEM_wr_en;
  assign mmio_rd  = (region == REG_MMIO) && !DMEM_wr_en;
  assign tx_push  = mmio_wr && (ofs == OFS_TX_DATA);
  assign tx_pop   = Tx_valid && Tx_ready;
  assign unused_addr = ^{DMEM_addr[30:8], DMEM_addr[1:0]};

  dmem_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .push_i      (tx_push),
    .push_data_i (DMEM_wr_data[7:0]),
    .pop_valid_o (Tx_valid),
    .pop_ready_i (Tx_ready),
    .pop_data_o  (Tx_data),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .count_o     (tx_count)
  );

  always_ff @(posedge Clk) begin
    if ((region == REG_RAM) && DMEM_wr_en) ram_q[word_idx] <= DMEM_wr_data;
  end

  always_comb begin
    rd_data_d = '0;
    if (!DMEM_rst) begin
      if (region == REG_RAM) begin
        rd_data_d = ram_q[word_idx];
      end else begin
        case (ofs)
          OFS_TIMER_LO:   rd_data_d = mtime_q[31:0];
          OFS_TIMER_HI:   rd_data_d = shadow_q;
          OFS_TIMECMP_LO: rd_data_d = mtimecmp_q[31:0];
          OFS_TIMECMP_HI: rd_data_d = mtimecmp_q[63:32];
          OFS_STATUS:     rd_data_d = status_word(tx_full, tx_empty,
                                        (32'(tx_count) > 32'd7) ? 3'd7 : 3'(tx_count), ovf_q);
          default:        rd_data_d = '0;
        endcase
      end
    end
  end

  // Reading TIMER_LO snapshots the upper half so a LO-then-HI pair is coherent.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    shadow_d   = shadow_q;
    ovf_d      = ovf_q;
    if (mmio_wr && (ofs == OFS_TIMECMP_LO)) mtimecmp_d[31:0]  = DMEM_wr_data;
    if (mmio_wr && (ofs == OFS_TIMECMP_HI)) mtimecmp_d[63:32] = DMEM_wr_data;
    if (mmio_rd && (ofs == OFS_TIMER_LO))   shadow_d = mtime_q[63:32];
    if (mmio_wr && (ofs == OFS_STATUS))     ovf_d = 1'b0;
    else if (tx_push && tx_full && !tx_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_data_q  <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      shadow_q   <= '0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      mtime_q    <= mtime_q + 64'd1;
      mtimecmp_q <= mtimecmp_d;
      shadow_q   <= shadow_d;
      ovf_q      <= ovf_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  assign DMEM_rd_data = rd_data_q;
  assign Timer_irq    = irq_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - directed self-checking bench for dmem_bridge
module tb_dmem_bridge;

  localparam logic [31:0] A_TLO  = 32'h8000_0000;
  localparam logic [31:0] A_THI  = 32'h8000_0004;
  localparam logic [31:0] A_CLO  = 32'h8000_0008;
  localparam logic [31:0] A_CHI  = 32'h8000_000C;
  localparam logic [31:0] A_TX   = 32'h8000_0010;
  localparam logic [31:0] A_STS  = 32'h8000_0014;
  localparam logic [31:0] A_UNM  = 32'h8000_0018;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] DMEM_addr = '0;
  logic [31:0] DMEM_wr_data = '0;
  logic        DMEM_wr_en = 1'b0;
  logic        DMEM_rst = 1'b0;
  logic [31:0] DMEM_rd_data;
  logic [7:0]  Tx_data;
  logic        Tx_valid;
  logic        Tx_ready = 1'b0;
  logic        Timer_irq;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  dmem_bridge dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .DMEM_addr    (DMEM_addr),
    .DMEM_wr_data (DMEM_wr_data),
    .DMEM_wr_en   (DMEM_wr_en),
    .DMEM_rst     (DMEM_rst),
    .DMEM_rd_data (DMEM_rd_data),
    .Tx_data      (Tx_data),
    .Tx_valid     (Tx_valid),
    .Tx_ready     (Tx_ready),
    .Timer_irq    (Timer_irq)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic we);
    @(negedge Clk);
    DMEM_addr    = a;
    DMEM_wr_data = d;
    DMEM_wr_en   = we;
    @(posedge Clk);
    #1;
    edges++;
  endtask

  logic [7:0] drain_exp [4];

  initial begin
    drain_exp[0] = 8'h62; drain_exp[1] = 8'h63; drain_exp[2] = 8'h64; drain_exp[3] = 8'h55;

    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    edges = 0;
    check("rst_rd_data", DMEM_rd_data, 32'h0);
    check("rst_tx_valid", {31'b0, Tx_valid}, 32'h0);
    check("rst_tx_data", {24'b0, Tx_data}, 32'h0);
    check("rst_irq", {31'b0, Timer_irq}, 32'h0);

    while (edges < 10) cycle(32'h0, 32'h0, 1'b0);
    cycle(A_TLO, 32'h0, 1'b0);
    check("timer_lo", DMEM_rd_data, 32'd10);
    cycle(A_THI, 32'h0, 1'b0);
    check("timer_hi", DMEM_rd_data, 32'd0);
    check("irq_default", {31'b0, Timer_irq}, 32'h0);

    cycle(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    cycle(32'h0000_0010, 32'h0, 1'b0);
    check("ram_rd", DMEM_rd_data, 32'hDEAD_BEEF);
    cycle(32'h0000_1010, 32'h0, 1'b0);
    check("ram_alias", DMEM_rd_data, 32'hDEAD_BEEF);
    cycle(32'h0000_0014, 32'h1234_5678, 1'b1);
    cycle(32'h0000_0010, 32'h0, 1'b0);
    check("ram_keep", DMEM_rd_data, 32'hDEAD_BEEF);
    cycle(32'h0000_0014, 32'h0, 1'b0);
    check("ram_rd2", DMEM_rd_data, 32'h1234_5678);

    cycle(A_CHI, 32'h0, 1'b1);
    cycle(A_CLO, 32'd50, 1'b1);
    cycle(A_CLO, 32'h0, 1'b0);
    check("cmp_lo", DMEM_rd_data, 32'd50);
    cycle(A_CHI, 32'h0, 1'b0);
    check("cmp_hi", DMEM_rd_data, 32'd0);
    while (edges < 50) cycle(32'h0, 32'h0, 1'b0);
    check("irq_before", {31'b0, Timer_irq}, 32'h0);
    cycle(32'h0, 32'h0, 1'b0);
    check("irq_rise", {31'b0, Timer_irq}, 32'h1);

    Tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle(A_TX, 32'h41 + i, 1'b1);
    cycle(A_STS, 32'h0, 1'b0);
    check("sts_full_ovf", DMEM_rd_data, 32'h31);
    cycle(A_TX, 32'h0, 1'b0);
    check("txdata_rd", DMEM_rd_data, 32'h0);
    cycle(A_UNM, 32'h0, 1'b0);
    check("unmapped", DMEM_rd_data, 32'h0);
    Tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain1_%0d", i), {24'b0, Tx_data}, 32'h41 + i);
      cycle(32'h0, 32'h0, 1'b0);
    end
    check("drain1_empty", {31'b0, Tx_valid}, 32'h0);
    cycle(A_STS, 32'h0, 1'b0);
    check("sts_empty_ovf", DMEM_rd_data, 32'h22);
    cycle(A_STS, 32'h0, 1'b1);
    cycle(A_STS, 32'h0, 1'b0);
    check("sts_ovf_clr", DMEM_rd_data, 32'h02);

    Tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle(A_TX, 32'h61 + i, 1'b1);
    Tx_ready = 1'b1;
    cycle(A_TX, 32'h55, 1'b1);
    Tx_ready = 1'b0;
    cycle(A_STS, 32'h0, 1'b0);
    check("sts_full_pushpop", DMEM_rd_data, 32'h11);
    Tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain2_%0d", i), {24'b0, Tx_data}, {24'b0, drain_exp[i]});
      cycle(32'h0, 32'h0, 1'b0);
    end
    check("drain2_empty", {31'b0, Tx_valid}, 32'h0);

    DMEM_rst = 1'b1;
    cycle(32'h0000_0010, 32'h0, 1'b0);
    DMEM_rst = 1'b0;
    check("dmem_rst", DMEM_rd_data, 32'h0);

    Tx_ready = 1'b0;
    cycle(A_TX, 32'h71, 1'b1);
    cycle(A_TX, 32'h72, 1'b1);
    Tx_ready = 1'b1;
    cycle(32'h0000_0010, 32'h0, 1'b0);
    check("pre_rst_head", {24'b0, Tx_data}, 32'h72);
    check("pre_rst_rd", DMEM_rd_data, 32'hDEAD_BEEF);
    #2 Reset = 1'b1;
    #1;
    check("midrst_valid", {31'b0, Tx_valid}, 32'h0);
    check("midrst_data", {24'b0, Tx_data}, 32'h0);
    check("midrst_rd", DMEM_rd_data, 32'h0);
    check("midrst_irq", {31'b0, Timer_irq}, 32'h0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    cycle(A_STS, 32'h0, 1'b0);
    check("post_rst_sts", DMEM_rd_data, 32'h02);
    cycle(32'h0000_0010, 32'h0, 1'b0);
    check("ram_survives", DMEM_rd_data, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
